// File: rtl/execute_stage_md.sv
// EX stage: operand select, ALU, branch/jump resolution, plus an iterative
// RV32M unit (shift-add multiply, restoring divide, one bit per cycle).
module execute_stage_md #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned REGADDR_W = 5,
    parameter bit          MULDIV_EN = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 valid_i,
    input  logic                 flush_i,
    input  logic [XLEN-1:0]      pc_i,
    input  logic [31:0]          instruction_i,
    input  logic [XLEN-1:0]      read_data1_i,
    input  logic [XLEN-1:0]      read_data2_i,
    input  logic [XLEN-1:0]      offset_i,
    input  logic [REGADDR_W-1:0] rs2_i,
    input  logic [REGADDR_W-1:0] rd_i,
    input  logic [4:0]           aluop_i,
    input  logic                 alusrc1_i,
    input  logic                 alusrc2_i,
    input  logic                 reg_dest_i,
    input  logic                 branch_i,
    input  logic                 jump_i,
    output logic                 stall_o,
    output logic                 valid_o,
    output logic [XLEN-1:0]      alu_result_o,
    output logic [XLEN-1:0]      read_data2_o,
    output logic [REGADDR_W-1:0] write_addr_reg_o,
    output logic [XLEN-1:0]      pc_new_o,
    output logic                 pc_select_o
);
    localparam int unsigned SHW      = $clog2(XLEN);
    localparam logic [6:0]  OPC_JALR = 7'b1100111;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state_q, state_d;

    logic [XLEN-1:0]      op1, op2, alu_res, link_addr, target;
    logic [SHW-1:0]       shamt;
    logic                 accept, is_md, taken, redirect, last_step;
    logic [XLEN-1:0]      alu_result_q, read_data2_q, pc_new_q;
    logic [REGADDR_W-1:0] write_addr_q;
    logic                 valid_q, pc_select_q;

    logic [XLEN-1:0]      hi_q, lo_q, mcand_q, dividend_q;
    logic [2:0]           md_op_q;
    logic                 neg_q, negr_q, div0_q;
    logic [SHW-1:0]       cnt_q;

    logic [2:0]           md_op;
    logic                 a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0]      a_mag, b_mag, hi_n, lo_n, md_result;
    logic [XLEN:0]        mul_sum, div_sh, div_diff;
    logic                 div_ok;
    logic [2*XLEN-1:0]    prod;
    logic                 unused_bits;

    assign unused_bits = ^{instruction_i[31:15], instruction_i[11:7]};

    assign op1       = alusrc1_i ? pc_i : read_data1_i;
    assign op2       = alusrc2_i ? offset_i : read_data2_i;
    assign shamt     = op2[SHW-1:0];
    assign stall_o   = (state_q == BUSY);
    assign accept    = valid_i & ~stall_o & ~flush_i;
    assign is_md     = MULDIV_EN & (aluop_i[4:3] == 2'b10);
    assign last_step = (cnt_q == SHW'(XLEN - 1));

    always_comb begin
        alu_res = '0;
        case (aluop_i)
            5'd0:    alu_res = op1 + op2;
            5'd1:    alu_res = op1 - op2;
            5'd2:    alu_res = op1 << shamt;
            5'd3:    alu_res = {{(XLEN-1){1'b0}}, $signed(op1) < $signed(op2)};
            5'd4:    alu_res = {{(XLEN-1){1'b0}}, op1 < op2};
            5'd5:    alu_res = op1 ^ op2;
            5'd6:    alu_res = op1 >> shamt;
            5'd7:    alu_res = $signed(op1) >>> shamt;
            5'd8:    alu_res = op1 | op2;
            5'd9:    alu_res = op1 & op2;
            5'd10:   alu_res = op2;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (instruction_i[14:12])
            3'b000:  taken = (read_data1_i == read_data2_i);
            3'b001:  taken = (read_data1_i != read_data2_i);
            3'b100:  taken = ($signed(read_data1_i) < $signed(read_data2_i));
            3'b101:  taken = ($signed(read_data1_i) >= $signed(read_data2_i));
            3'b110:  taken = (read_data1_i < read_data2_i);
            3'b111:  taken = (read_data1_i >= read_data2_i);
            default: taken = 1'b0;
        endcase
    end

    assign redirect  = jump_i | (branch_i & taken);
    assign link_addr = pc_i + XLEN'(4);
    assign target    = (jump_i && instruction_i[6:0] == OPC_JALR)
                     ? ((read_data1_i + offset_i) & {{(XLEN-1){1'b1}}, 1'b0})
                     : (pc_i + offset_i);

    // Both units work on magnitudes; the sign is restored on the final step.
    assign md_op = aluop_i[2:0];
    assign a_sgn = (md_op == 3'd1) | (md_op == 3'd2) | (md_op == 3'd4) | (md_op == 3'd6);
    assign b_sgn = (md_op == 3'd1) | (md_op == 3'd4) | (md_op == 3'd6);
    assign a_neg = a_sgn & op1[XLEN-1];
    assign b_neg = b_sgn & op2[XLEN-1];
    assign a_mag = a_neg ? -op1 : op1;
    assign b_mag = b_neg ? -op2 : op2;

    assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    assign div_sh   = {hi_q, lo_q[XLEN-1]};
    assign div_diff = div_sh - {1'b0, mcand_q};
    assign div_ok   = ~div_diff[XLEN];
    assign hi_n     = md_op_q[2] ? (div_ok ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0])
                                 : mul_sum[XLEN:1];
    assign lo_n     = md_op_q[2] ? {lo_q[XLEN-2:0], div_ok}
                                 : {mul_sum[0], lo_q[XLEN-1:1]};
    assign prod     = neg_q ? -{hi_n, lo_n} : {hi_n, lo_n};

    always_comb begin
        md_result = '0;
        if (md_op_q[2]) begin
            if (div0_q)
                md_result = md_op_q[1] ? dividend_q : '1;
            else if (md_op_q[1])
                md_result = negr_q ? -hi_n : hi_n;
            else
                md_result = neg_q ? -lo_n : lo_n;
        end else if (md_op_q[1:0] == 2'b00) begin
            md_result = prod[XLEN-1:0];
        end else begin
            md_result = prod[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: state_d = (accept && is_md) ? BUSY : IDLE;
            BUSY: begin
                if (flush_i)
                    state_d = IDLE;
                else if (last_step)
                    state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            alu_result_q <= '0;
            read_data2_q <= '0;
            pc_new_q     <= '0;
            write_addr_q <= '0;
            valid_q      <= 1'b0;
            pc_select_q  <= 1'b0;
            hi_q         <= '0;
            lo_q         <= '0;
            mcand_q      <= '0;
            dividend_q   <= '0;
            md_op_q      <= '0;
            neg_q        <= 1'b0;
            negr_q       <= 1'b0;
            div0_q       <= 1'b0;
            cnt_q        <= '0;
        end else begin
            valid_q     <= 1'b0;
            pc_select_q <= 1'b0;
            if (state_q == BUSY && !flush_i) begin
                hi_q  <= hi_n;
                lo_q  <= lo_n;
                cnt_q <= cnt_q + SHW'(1);
                if (last_step) begin
                    alu_result_q <= md_result;
                    valid_q      <= 1'b1;
                end
            end
            if (accept) begin
                read_data2_q <= read_data2_i;
                write_addr_q <= reg_dest_i ? rs2_i : rd_i;
                if (is_md) begin
                    md_op_q    <= md_op;
                    hi_q       <= '0;
                    lo_q       <= md_op[2] ? a_mag : b_mag;
                    mcand_q    <= md_op[2] ? b_mag : a_mag;
                    dividend_q <= op1;
                    neg_q      <= a_neg ^ b_neg;
                    negr_q     <= a_neg;
                    div0_q     <= (op2 == '0);
                    cnt_q      <= '0;
                end else begin
                    alu_result_q <= jump_i ? link_addr : alu_res;
                    pc_new_q     <= target;
                    pc_select_q  <= redirect;
                    valid_q      <= 1'b1;
                end
            end
        end
    end

    assign valid_o          = valid_q;
    assign alu_result_o     = alu_result_q;
    assign read_data2_o     = read_data2_q;
    assign write_addr_reg_o = write_addr_q;
    assign pc_new_o         = pc_new_q;
    assign pc_select_o      = pc_select_q;
endmodule

// File: tb/tb_execute_stage_md.sv
// Scoreboard bench for execute_stage_md: expectations are queued at accept and
// compared in order whenever valid_o is seen.
module tb_execute_stage_md;
    typedef struct {
        logic [31:0] pc, ins, rd1, rd2, off;
        logic [4:0]  op, rs2, rd;
        logic        s1, s2, rdst, br, jp;
    } instr_t;

    typedef struct {
        string       name;
        logic [31:0] res, pcn, d2;
        logic [4:0]  wa;
        logic        psel;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_i, valid_i, flush_i;
    logic [31:0] pc_i, instruction_i, read_data1_i, read_data2_i, offset_i;
    logic [4:0]  rs2_i, rd_i, aluop_i;
    logic        alusrc1_i, alusrc2_i, reg_dest_i, branch_i, jump_i;
    logic        stall_o, valid_o, pc_select_o;
    logic [31:0] alu_result_o, read_data2_o, pc_new_o;
    logic [4:0]  write_addr_reg_o;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    execute_stage_md #(.XLEN(32), .REGADDR_W(5), .MULDIV_EN(1'b1)) dut (
        .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .flush_i(flush_i),
        .pc_i(pc_i), .instruction_i(instruction_i), .read_data1_i(read_data1_i),
        .read_data2_i(read_data2_i), .offset_i(offset_i), .rs2_i(rs2_i), .rd_i(rd_i),
        .aluop_i(aluop_i), .alusrc1_i(alusrc1_i), .alusrc2_i(alusrc2_i),
        .reg_dest_i(reg_dest_i), .branch_i(branch_i), .jump_i(jump_i),
        .stall_o(stall_o), .valid_o(valid_o), .alu_result_o(alu_result_o),
        .read_data2_o(read_data2_o), .write_addr_reg_o(write_addr_reg_o),
        .pc_new_o(pc_new_o), .pc_select_o(pc_select_o)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic instr_t mk(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        instr_t t;
        t.pc = 32'h1000; t.ins = 32'h0000_0033; t.rd1 = a; t.rd2 = b; t.off = 32'h10;
        t.op = op; t.rs2 = 5'd7; t.rd = 5'd9;
        t.s1 = 1'b0; t.s2 = 1'b0; t.rdst = 1'b0; t.br = 1'b0; t.jp = 1'b0;
        return t;
    endfunction

    function automatic exp_t model(input instr_t t);
        exp_t e;
        logic [31:0] a, b, r;
        logic signed [31:0] sa, sbv;
        logic signed [63:0] x, y, p;
        logic tk;
        a = t.s1 ? t.pc : t.rd1;
        b = t.s2 ? t.off : t.rd2;
        sa = a; sbv = b;
        x = {{32{a[31]}}, a};
        y = {{32{b[31]}}, b};
        r = '0;
        case (t.op)
            5'd0:  r = a + b;
            5'd1:  r = a - b;
            5'd2:  r = a << b[4:0];
            5'd3:  r = (sa < sbv) ? 32'd1 : 32'd0;
            5'd4:  r = (a < b) ? 32'd1 : 32'd0;
            5'd5:  r = a ^ b;
            5'd6:  r = a >> b[4:0];
            5'd7:  r = sa >>> b[4:0];
            5'd8:  r = a | b;
            5'd9:  r = a & b;
            5'd10: r = b;
            5'd16: r = a * b;
            5'd17: begin p = x * y; r = p[63:32]; end
            5'd18: begin p = x * $signed({32'b0, b}); r = p[63:32]; end
            5'd19: begin p = $signed({32'b0, a}) * $signed({32'b0, b}); r = p[63:32]; end
            5'd20: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                else r = sa / sbv;
            end
            5'd21: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            5'd22: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
                else r = sa % sbv;
            end
            5'd23: r = (b == 0) ? a : a % b;
            default: r = '0;
        endcase
        case (t.ins[14:12])
            3'b000:  tk = (t.rd1 == t.rd2);
            3'b001:  tk = (t.rd1 != t.rd2);
            3'b100:  tk = ($signed(t.rd1) < $signed(t.rd2));
            3'b101:  tk = ($signed(t.rd1) >= $signed(t.rd2));
            3'b110:  tk = (t.rd1 < t.rd2);
            3'b111:  tk = (t.rd1 >= t.rd2);
            default: tk = 1'b0;
        endcase
        e.name = "";
        e.res  = t.jp ? t.pc + 32'd4 : r;
        e.psel = t.jp | (t.br & tk);
        e.pcn  = (t.jp && t.ins[6:0] == 7'b1100111) ? ((t.rd1 + t.off) & 32'hFFFF_FFFE) : t.pc + t.off;
        e.d2   = t.rd2;
        e.wa   = t.rdst ? t.rs2 : t.rd;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!reset_i && valid_o) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_valid", valid_o, 1'b0);
            end else begin
                mon_e = sb.pop_front();
                check_eq({mon_e.name, "_res"}, alu_result_o, mon_e.res);
                check_eq({mon_e.name, "_psel"}, pc_select_o, mon_e.psel);
                check_eq({mon_e.name, "_d2"}, read_data2_o, mon_e.d2);
                check_eq({mon_e.name, "_wa"}, write_addr_reg_o, mon_e.wa);
                if (mon_e.psel)
                    check_eq({mon_e.name, "_pcn"}, pc_new_o, mon_e.pcn);
            end
        end
    end

    task automatic drive(input instr_t t);
        pc_i = t.pc; instruction_i = t.ins; read_data1_i = t.rd1; read_data2_i = t.rd2;
        offset_i = t.off; rs2_i = t.rs2; rd_i = t.rd; aluop_i = t.op;
        alusrc1_i = t.s1; alusrc2_i = t.s2; reg_dest_i = t.rdst;
        branch_i = t.br; jump_i = t.jp; valid_i = 1'b1;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input instr_t t, input string name);
        int unsigned guard;
        exp_t e;
        drive(t);
        guard = 0;
        while (stall_o && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check_eq({name, "_accept_timeout"}, stall_o, 1'b0);
        e = model(t);
        e.name = name;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    task automatic wait_md(output int unsigned n);
        n = 1;
        while (stall_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        n = n - 1;
    endtask

    task automatic check_reset(input string p);
        check_eq({p, "_valid"}, valid_o, 1'b0);
        check_eq({p, "_stall"}, stall_o, 1'b0);
        check_eq({p, "_res"}, alu_result_o, 32'd0);
        check_eq({p, "_psel"}, pc_select_o, 1'b0);
        check_eq({p, "_pcn"}, pc_new_o, 32'd0);
        check_eq({p, "_d2"}, read_data2_o, 32'd0);
        check_eq({p, "_wa"}, write_addr_reg_o, 5'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        instr_t t;
        int unsigned n, nv;
        reset_i = 1'b1; flush_i = 1'b0;
        drive(mk(5'd0, 32'd0, 32'd0));
        valid_i = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("init");
        reset_i = 1'b0;

        issue(mk(5'd0, 32'd5, 32'hFFFF_FFF9), "add");
        check_eq("add_valid", valid_o, 1'b1);
        check_eq("add_const", alu_result_o, 32'hFFFF_FFFE);
        issue(mk(5'd7, 32'h8000_0000, 32'd4), "sra");
        check_eq("sra_valid", valid_o, 1'b1);
        check_eq("sra_const", alu_result_o, 32'hF800_0000);

        for (int op = 0; op < 12; op++) begin
            for (int k = 0; k < 2; k++) begin
                t = mk(5'(op), $urandom, $urandom);
                t.pc = $urandom; t.off = $urandom; t.rd = 5'($urandom); t.rs2 = 5'($urandom);
                t.s1 = k[0]; t.s2 = ~k[0]; t.rdst = k[0];
                issue(t, $sformatf("alu%0d_%0d", op, k));
            end
        end

        t = mk(5'd1, 32'hFFFF_FFFF, 32'd1);
        t.pc = 32'h100; t.off = 32'h20; t.br = 1'b1; t.ins = {17'b0, 3'b100, 5'b0, 7'b1100011};
        issue(t, "blt");
        check_eq("blt_psel_const", pc_select_o, 1'b1);
        check_eq("blt_pcn_const", pc_new_o, 32'h120);
        t.ins = {17'b0, 3'b110, 5'b0, 7'b1100011};
        issue(t, "bltu");
        check_eq("bltu_psel_const", pc_select_o, 1'b0);
        t = mk(5'd0, 32'h1001, 32'd0);
        t.pc = 32'h40; t.off = 32'd2; t.jp = 1'b1; t.ins = 32'h0000_0067;
        issue(t, "jalr");
        check_eq("jalr_pcn_const", pc_new_o, 32'h1002);
        check_eq("jalr_res_const", alu_result_o, 32'h44);
        t = mk(5'd0, 32'h0, 32'd0);
        t.pc = 32'h200; t.off = 32'hFFFF_FFF8; t.jp = 1'b1; t.ins = 32'h0000_006F;
        issue(t, "jal");

        issue(mk(5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF), "mulhu");
        check_eq("mulhu_stall_first", stall_o, 1'b1);
        wait_md(n);
        check_eq("mulhu_stall_cycles", n, 32);
        check_eq("mulhu_done_valid", valid_o, 1'b1);
        check_eq("mulhu_const", alu_result_o, 32'hFFFF_FFFE);
        issue(mk(5'd16, 32'h1234_5678, 32'h9ABC_DEF0), "mul_b2b");
        check_eq("mul_b2b_stall", stall_o, 1'b1);
        wait_md(n);
        check_eq("mul_b2b_cycles", n, 32);

        issue(mk(5'd20, 32'd7, 32'd0), "div0");
        wait_md(n);
        check_eq("div0_const", alu_result_o, 32'hFFFF_FFFF);
        issue(mk(5'd20, 32'h8000_0000, 32'hFFFF_FFFF), "divovf");
        wait_md(n);
        check_eq("divovf_const", alu_result_o, 32'h8000_0000);
        issue(mk(5'd22, 32'hFFFF_FFF9, 32'd2), "rem");
        wait_md(n);
        check_eq("rem_const", alu_result_o, 32'hFFFF_FFFF);

        for (int op = 16; op < 24; op++) begin
            for (int k = 0; k < 2; k++) begin
                t = mk(5'(op), $urandom, k[0] ? $urandom : $urandom_range(1, 100));
                issue(t, $sformatf("md%0d_%0d", op, k));
                wait_md(n);
                check_eq($sformatf("md%0d_%0d_cycles", op, k), n, 32);
            end
        end

        issue(mk(5'd21, 32'd1000, 32'd3), "divu_flush");
        repeat (9) @(negedge clk);
        flush_i = 1'b1;
        void'(sb.pop_back());
        @(posedge clk);
        @(negedge clk);
        flush_i = 1'b0;
        check_eq("flush_stall", stall_o, 1'b0);
        check_eq("flush_valid", valid_o, 1'b0);
        nv = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (valid_o) nv++;
        end
        check_eq("flush_no_valid", nv, 0);

        drive(mk(5'd0, 32'd1, 32'd2));
        flush_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush_i = 1'b0;
        valid_i = 1'b0;
        check_eq("flush_accept_valid", valid_o, 1'b0);

        issue(mk(5'd20, 32'd100, 32'd7), "div_rst");
        repeat (5) @(negedge clk);
        reset_i = 1'b1;
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        check_reset("rst_mid");
        @(posedge clk);
        @(negedge clk);
        reset_i = 1'b0;
        issue(mk(5'd0, 32'd20, 32'd22), "add_post_rst");
        check_eq("add_post_rst_valid", valid_o, 1'b1);

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        check_eq("sb_drain", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
